// File: rtl/window_pkg.sv
// Shared 3x3 window definitions: slot numbering and the slot-extraction macro
// used by the window generator and by the window-based filters.
`ifndef WINDOW_PKG_SV
`define WINDOW_PKG_SV

// Selects slot I of a packed window; expects a dataW parameter in scope.
`define WIN_SLOT(I) [(I)*dataW +: dataW]

package window_pkg;

    localparam int WIN_ROWS   = 3;
    localparam int WIN_COLS   = 3;
    localparam int WIN_N      = WIN_ROWS * WIN_COLS;
    localparam int WIN_CENTER = 4;

    // Row 0 is the oldest line (y-2), column 0 the oldest pixel (x-2).
    localparam int WIN_TL = 0;
    localparam int WIN_TC = 1;
    localparam int WIN_TR = 2;
    localparam int WIN_ML = 3;
    localparam int WIN_MC = 4;
    localparam int WIN_MR = 5;
    localparam int WIN_BL = 6;
    localparam int WIN_BC = 7;
    localparam int WIN_BR = 8;

    function automatic int win_slot(input int r, input int c);
        return r * WIN_COLS + c;
    endfunction

endpackage

`endif

// File: rtl/line_buffer.sv
// One image line of storage: synchronous write with a read-first combinational
// read at the same address, so a read returns the value from the previous line.
module line_buffer #(
    parameter int dataW = 8,
    parameter int DEPTH = 640
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [dataW-1:0]         wr_data,
    output logic [dataW-1:0]         rd_data
);

    logic [dataW-1:0] mem [DEPTH];

    // Storage is deliberately unreset; stale contents are never exposed downstream.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wr_data;
        end
    end

    assign rd_data = mem[addr];

endmodule

// File: rtl/window3x3_gen.sv
// Streaming 3x3 neighbourhood generator: two line buffers feed a 3x3 shift
// window, emitted once the newest pixel is at x>=2, y>=2.
module window3x3_gen
  import window_pkg::*;
#(
  parameter int dataW = 8,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic                     in_sof,
  input  logic [dataW-1:0]         din,
  output logic                     out_valid,
  output logic                     out_eof,
  output logic [dataW*WIN_N-1:0]   window
);

  // Handshake: in_valid qualifies din and in_sof; there is no ready, so every
  // strobed pixel is consumed. out_valid is a one-cycle pulse with no stall.

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  logic [XW-1:0]            x, cur_x, nx;
  logic [YW-1:0]            y, cur_y, ny;
  logic [dataW-1:0]         lb1_rd, lb2_rd;
  logic [dataW*WIN_N-1:0]   win_sr, win_next;
  logic                     emit, last_px;

  // A start-of-frame pixel is position (0,0) regardless of where the counters are.
  always_comb begin
    cur_x = in_sof ? '0 : x;
    cur_y = in_sof ? '0 : y;
    if (cur_x == X_LAST) begin
      nx = '0;
      ny = (cur_y == Y_LAST) ? '0 : cur_y + YW'(1);
    end else begin
      nx = cur_x + XW'(1);
      ny = cur_y;
    end
  end

  assign emit    = in_valid && (cur_x >= XW'(2)) && (cur_y >= YW'(2));
  assign last_px = (cur_x == X_LAST) && (cur_y == Y_LAST);

  line_buffer #(
    .dataW (dataW),
    .DEPTH (IMG_W)
  ) u_lb1 (
    .clk     (clk),
    .we      (in_valid),
    .addr    (cur_x),
    .wr_data (din),
    .rd_data (lb1_rd)
  );

  line_buffer #(
    .dataW (dataW),
    .DEPTH (IMG_W)
  ) u_lb2 (
    .clk     (clk),
    .we      (in_valid),
    .addr    (cur_x),
    .wr_data (lb1_rd),
    .rd_data (lb2_rd)
  );

  always_comb begin
    win_next = win_sr;
    for (int r = 0; r < WIN_ROWS; r++) begin
      win_next `WIN_SLOT(win_slot(r, 0)) = win_sr `WIN_SLOT(win_slot(r, 1));
      win_next `WIN_SLOT(win_slot(r, 1)) = win_sr `WIN_SLOT(win_slot(r, 2));
    end
    win_next `WIN_SLOT(WIN_TR) = lb2_rd;
    win_next `WIN_SLOT(WIN_MR) = lb1_rd;
    win_next `WIN_SLOT(WIN_BR) = din;
  end

  // The shift window tracks every accept; the output copy only loads on emits
  // so that window stays put between pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x         <= '0;
      y         <= '0;
      win_sr    <= '0;
      window    <= '0;
      out_valid <= 1'b0;
      out_eof   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_eof   <= 1'b0;
      if (in_valid) begin
        x      <= nx;
        y      <= ny;
        win_sr <= win_next;
        if (emit) begin
          window    <= win_next;
          out_valid <= 1'b1;
          out_eof   <= last_px;
        end
      end
    end
  end

endmodule

// File: tb/tb_window3x3_gen.sv
// Bench for window3x3_gen: 4x4/8-bit instance driven by tables, hand sequences
// and random streams against a frame-array model; 5x3/12-bit instance for corners.
module tb_window3x3_gen;

  localparam int W = 4;
  localparam int H = 4;

  logic         clk;
  logic         rst;
  logic         in_valid, in_sof;
  logic [7:0]   din;
  logic         out_valid, out_eof;
  logic [71:0]  window;

  logic         c_valid, c_sof;
  logic [11:0]  c_din;
  logic         c_out_valid, c_out_eof;
  logic [107:0] c_window;

  int n_checks = 0;
  int n_fail   = 0;
  int pulse_cnt;

  window3x3_gen #(.dataW(8), .IMG_W(W), .IMG_H(H)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .din(din),
    .out_valid(out_valid), .out_eof(out_eof), .window(window)
  );

  window3x3_gen #(.dataW(12), .IMG_W(5), .IMG_H(3)) u_dut5 (
    .clk(clk), .rst(rst), .in_valid(c_valid), .in_sof(c_sof), .din(c_din),
    .out_valid(c_out_valid), .out_eof(c_out_eof), .window(c_window)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / reference model ----------------
  logic [72:0] exp_q[$];
  logic        exp_pulse;
  logic [71:0] held_win;
  int          mx, my;
  logic [7:0]  img[H][W];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    mx = 0;
    my = 0;
    exp_q.delete();
    exp_pulse = 1'b0;
    held_win = '0;
  endfunction

  // Frame kept as a 2-D array; a window is just the 3x3 block ending at the newest pixel.
  function automatic void model_cycle(input logic v, input logic s, input logic [7:0] d);
    logic [71:0] w;
    exp_pulse = 1'b0;
    if (!v) return;
    if (s) begin
      mx = 0;
      my = 0;
    end
    img[my][mx] = d;
    if (mx >= 2 && my >= 2) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          w[(r*3+c)*8 +: 8] = img[my-2+r][mx-2+c];
      exp_q.push_back({(mx == W-1 && my == H-1), w});
      exp_pulse = 1'b1;
    end
    mx++;
    if (mx == W) begin
      mx = 0;
      my = (my == H-1) ? 0 : my + 1;
    end
  endfunction

  task automatic check_outputs();
    logic [72:0] e;
    chk("pulse", out_valid, exp_pulse);
    if (exp_pulse) begin
      e = exp_q.pop_front();
      chk("window", window, e[71:0]);
      chk("eof", out_eof, e[72]);
      held_win = e[71:0];
    end else begin
      chk("hold", window, held_win);
      chk("eof_low", out_eof, 1'b0);
    end
    if (out_valid) pulse_cnt++;
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic v, input logic s, input logic [7:0] d);
    @(negedge clk);
    check_outputs();
    in_valid = v;
    in_sof   = s;
    din      = d;
    model_cycle(v, s, d);
  endtask

  typedef struct {
    logic        sof;
    logic [7:0]  pix;
    logic        exp_valid;
    logic        exp_eof;
    logic [71:0] exp_win;
  } vec_t;

  vec_t tbl[16];

  task automatic run_table(input logic with_sof);
    for (int i = 0; i < 16; i++) begin
      step(1'b1, tbl[i].sof & with_sof, tbl[i].pix);
      @(posedge clk);
      #1;
      chk("tbl_valid", out_valid, tbl[i].exp_valid);
      if (tbl[i].exp_valid) begin
        chk("tbl_window", window, tbl[i].exp_win);
        chk("tbl_eof", out_eof, tbl[i].exp_eof);
      end
    end
  endtask

  task automatic test5_corners();
    logic [107:0] ew;
    int px, py, n5;
    n5 = 0;
    for (int yy = 0; yy < 3; yy++) begin
      for (int xx = 0; xx < 5; xx++) begin
        @(negedge clk);
        c_valid = 1'b1;
        c_sof   = (xx == 0 && yy == 0);
        c_din   = (xx == 2 && yy == 1) ? 12'h000 : 12'hFFF;
        @(posedge clk);
        #1;
        chk("t5_valid", c_out_valid, (xx >= 2 && yy >= 2));
        if (c_out_valid) n5++;
        if (xx >= 2 && yy >= 2) begin
          for (int s = 0; s < 9; s++) begin
            px = xx - 2 + s % 3;
            py = yy - 2 + s / 3;
            ew[s*12 +: 12] = (px == 2 && py == 1) ? 12'h000 : 12'hFFF;
          end
          chk("t5_window", c_window, ew);
          chk("t5_eof", c_out_eof, (xx == 4));
        end
      end
    end
    @(negedge clk);
    c_valid = 1'b0;
    c_sof   = 1'b0;
    chk("t5_pulses", n5, 3);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_sof = 1'b0; din = '0;
    c_valid = 1'b0; c_sof = 1'b0; c_din = '0;
    model_reset();
    pulse_cnt = 0;

    for (int i = 0; i < 16; i++) begin
      tbl[i].sof       = (i == 0);
      tbl[i].pix       = 8'(((i / 4) << 4) | (i % 4));
      tbl[i].exp_valid = (i % 4 >= 2) && (i / 4 >= 2);
      tbl[i].exp_eof   = (i == 15);
      tbl[i].exp_win   = '0;
    end
    tbl[10].exp_win = 72'h22_21_20_12_11_10_02_01_00;
    tbl[11].exp_win = 72'h23_22_21_13_12_11_03_02_01;
    tbl[14].exp_win = 72'h32_31_30_22_21_20_12_11_10;
    tbl[15].exp_win = 72'h33_32_31_23_22_21_13_12_11;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_eof", out_eof, 1'b0);
    chk("rst_window", window, '0);
    chk("rst_c_valid", c_out_valid, 1'b0);
    chk("rst_c_window", c_window, '0);
    @(negedge clk);
    rst = 1'b0;

    // contiguous frame
    pulse_cnt = 0;
    run_table(1'b1);
    step(1'b0, 1'b0, 8'h00);
    chk("t2_pulses", pulse_cnt, 4);

    // asynchronous reset mid-frame, right after a pulse
    for (int i = 0; i <= 10; i++) step(1'b1, (i == 0), tbl[i].pix);
    @(posedge clk);
    #1;
    chk("pre_rst_valid", out_valid, 1'b1);
    #1;
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("midrst_valid", out_valid, 1'b0);
    chk("midrst_eof", out_eof, 1'b0);
    chk("midrst_window", window, '0);
    repeat (2) begin
      @(negedge clk);
      chk("rst_hold_valid", out_valid, 1'b0);
      chk("rst_hold_window", window, '0);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // gapped input; idle cycles carry junk din/in_sof that must be ignored
    pulse_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      while ($urandom_range(1, 0) == 1)
        step(1'b0, 1'($urandom_range(1, 0)), 8'($urandom_range(255, 0)));
      step(1'b1, (i == 0), tbl[i].pix);
    end
    step(1'b0, 1'b0, 8'h00);
    chk("t3_pulses", pulse_cnt, 4);

    // early sof after pixel (1,2), then a full frame
    pulse_cnt = 0;
    for (int i = 0; i <= 9; i++) step(1'b1, (i == 0), tbl[i].pix);
    for (int i = 0; i < 16; i++) step(1'b1, (i == 0), tbl[i].pix);
    step(1'b0, 1'b0, 8'h00);
    chk("t4_pulses", pulse_cnt, 4);

    // two frames, sof only on the first
    pulse_cnt = 0;
    run_table(1'b1);
    run_table(1'b0);
    step(1'b0, 1'b0, 8'h00);
    chk("t6_pulses", pulse_cnt, 8);

    // wider pixels, non-square frame
    test5_corners();

    // random data, random gaps, occasional random restart
    for (int i = 0; i < 60; i++) begin
      while ($urandom_range(2, 0) == 0)
        step(1'b0, 1'($urandom_range(1, 0)), 8'($urandom_range(255, 0)));
      step(1'b1, (i == 0) || ($urandom_range(29, 0) == 0), 8'($urandom_range(255, 0)));
    end
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
